// File: rtl/washer_sensor_if.sv
// Actuator/sensor bundle between the washer controller and its plant model.
// master: controller side (drives actuators); slave: plant side (drives sensors).
interface washer_sensor_if #(
  parameter int CNT_W = 8
);
  logic             lock;
  logic             fill_valve;
  logic             drain_valve;
  logic             soak;
  logic             wash;
  logic             motor;
  logic             fill;
  logic             soap_add;
  logic             cycle_timeout;
  logic             drain;
  logic             spin_timeout;
  logic [CNT_W-1:0] level;
  logic             fault;

  modport master (
    output lock,
    output fill_valve,
    output drain_valve,
    output soak,
    output wash,
    output motor,
    input  fill,
    input  soap_add,
    input  cycle_timeout,
    input  drain,
    input  spin_timeout,
    input  level,
    input  fault
  );

  modport slave (
    input  lock,
    input  fill_valve,
    input  drain_valve,
    input  soak,
    input  wash,
    input  motor,
    output fill,
    output soap_add,
    output cycle_timeout,
    output drain,
    output spin_timeout,
    output level,
    output fault
  );
endinterface

// File: rtl/washer_sensor_model.sv
// Plant model for the washer: water level, soap/wash/spin timers, interlock.
// Ports: clk, rst (async high), io (slave: actuators in, sensors/level/fault out).
module washer_sensor_model #(
  parameter int FULL_LEVEL  = 4,
  parameter int SOAP_CYCLES = 2,
  parameter int WASH_CYCLES = 6,
  parameter int SPIN_CYCLES = 5,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  washer_sensor_if.slave  io
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FULL_LEVEL);
  localparam logic [CNT_W-1:0] SOAP = CNT_W'(SOAP_CYCLES);
  localparam logic [CNT_W-1:0] WASH = CNT_W'(WASH_CYCLES);
  localparam logic [CNT_W-1:0] SPIN = CNT_W'(SPIN_CYCLES);
  localparam logic [CNT_W-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] level_q;
  logic [CNT_W-1:0] soap_q;
  logic [CNT_W-1:0] wash_q;
  logic [CNT_W-1:0] spin_q;
  logic             drain_seen_q;
  logic             fault_q;

  logic [CNT_W-1:0] level_d;
  logic [CNT_W-1:0] soap_d;
  logic [CNT_W-1:0] wash_d;
  logic [CNT_W-1:0] spin_d;
  logic             drain_seen_d;
  logic             trip;
  logic             freeze;
  logic             full;

  // Interlock violation this edge; it wins over every counter update.
  assign trip   = !io.lock && (io.motor || io.fill_valve);
  assign freeze = fault_q || trip;
  assign full   = (level_q == FULL);

  always_comb begin
    level_d = level_q;
    unique case (1'b1)
      io.fill_valve && !io.drain_valve:
        if (level_q < FULL) level_d = level_q + ONE;
      io.drain_valve && !io.fill_valve:
        if (level_q > ZERO) level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    drain_seen_d = drain_seen_q;
    if (io.drain_valve)
      drain_seen_d = 1'b1;
    else if (io.fill_valve)
      drain_seen_d = 1'b0;
  end

  always_comb begin
    soap_d = soap_q;
    if (!io.soak)
      soap_d = ZERO;
    else if (full && soap_q < SOAP)
      soap_d = soap_q + ONE;
  end

  // Motor pauses during wash hold the count rather than restarting it.
  always_comb begin
    wash_d = wash_q;
    if (!io.wash)
      wash_d = ZERO;
    else if (io.motor && wash_q < WASH)
      wash_d = wash_q + ONE;
  end

  always_comb begin
    spin_d = spin_q;
    if (!io.motor)
      spin_d = ZERO;
    else if (!io.wash && io.drain_valve && spin_q < SPIN)
      spin_d = spin_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q      <= '0;
      soap_q       <= '0;
      wash_q       <= '0;
      spin_q       <= '0;
      drain_seen_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      if (trip)
        fault_q <= 1'b1;
      if (!freeze) begin
        level_q      <= level_d;
        soap_q       <= soap_d;
        wash_q       <= wash_d;
        spin_q       <= spin_d;
        drain_seen_q <= drain_seen_d;
      end
    end
  end

  assign io.level         = level_q;
  assign io.fault         = fault_q;
  assign io.fill          = full;
  assign io.soap_add      = (soap_q == SOAP);
  assign io.cycle_timeout = (wash_q == WASH);
  assign io.spin_timeout  = (spin_q == SPIN);
  assign io.drain         = drain_seen_q && (level_q == ZERO)
                            && io.drain_valve;

endmodule

// File: tb/tb_washer_sensor_model.sv
// Directed vector bench for washer_sensor_model.
// Table of per-edge stimulus/expectations plus async reset sequences.
module tb_washer_sensor_model;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  washer_sensor_if #(.CNT_W(CNT_W)) io ();

  washer_sensor_model #(
    .FULL_LEVEL (4),
    .SOAP_CYCLES(2),
    .WASH_CYCLES(6),
    .SPIN_CYCLES(5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lock;
    logic       fv;
    logic       dv;
    logic       soak;
    logic       wash;
    logic       motor;
    logic [7:0] level;
    logic       fill;
    logic       soap;
    logic       ct;
    logic       drn;
    logic       spin;
    logic       fault;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [13:0] obs();
    return {io.level, io.fill, io.soap_add, io.cycle_timeout,
            io.drain, io.spin_timeout, io.fault};
  endfunction

  task automatic check(input string nm, input logic [13:0] got,
                       input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic l, input logic f, input logic d,
                       input logic s, input logic w, input logic m);
    io.lock        = l;
    io.fill_valve  = f;
    io.drain_valve = d;
    io.soak        = s;
    io.wash        = w;
    io.motor       = m;
  endtask

  task automatic add(input logic l, f, d, s, w, m,
                     input logic [7:0] lv,
                     input logic fl, sp, ct, dr, sn, ft);
    vec_t v;
    v.lock = l; v.fv = f; v.dv = d; v.soak = s; v.wash = w; v.motor = m;
    v.level = lv; v.fill = fl; v.soap = sp; v.ct = ct;
    v.drn = dr; v.spin = sn; v.fault = ft;
    tbl.push_back(v);
  endtask

  initial begin
    // fill to full, saturate
    add(1,1,0,0,0,0, 1, 0,0,0,0,0,0);
    add(1,1,0,0,0,0, 2, 0,0,0,0,0,0);
    add(1,1,0,0,0,0, 3, 0,0,0,0,0,0);
    add(1,1,0,0,0,0, 4, 1,0,0,0,0,0);
    add(1,1,0,0,0,0, 4, 1,0,0,0,0,0);
    // soak
    add(1,0,0,1,0,0, 4, 1,0,0,0,0,0);
    add(1,0,0,1,0,0, 4, 1,1,0,0,0,0);
    add(1,0,0,1,0,0, 4, 1,1,0,0,0,0);
    add(1,0,0,0,0,0, 4, 1,0,0,0,0,0);
    // wash with motor gap
    add(1,0,0,0,1,1, 4, 1,0,0,0,0,0);
    add(1,0,0,0,1,1, 4, 1,0,0,0,0,0);
    add(1,0,0,0,1,1, 4, 1,0,0,0,0,0);
    add(1,0,0,0,1,0, 4, 1,0,0,0,0,0);
    add(1,0,0,0,1,0, 4, 1,0,0,0,0,0);
    add(1,0,0,0,1,1, 4, 1,0,0,0,0,0);
    add(1,0,0,0,1,1, 4, 1,0,0,0,0,0);
    add(1,0,0,0,1,1, 4, 1,0,1,0,0,0);
    add(1,0,0,0,1,1, 4, 1,0,1,0,0,0);
    add(1,0,0,0,0,0, 4, 1,0,0,0,0,0);
    // drain
    add(1,0,1,0,0,0, 3, 0,0,0,0,0,0);
    add(1,0,1,0,0,0, 2, 0,0,0,0,0,0);
    add(1,0,1,0,0,0, 1, 0,0,0,0,0,0);
    add(1,0,1,0,0,0, 0, 0,0,0,1,0,0);
    // spin
    add(1,0,1,0,0,1, 0, 0,0,0,1,0,0);
    add(1,0,1,0,0,1, 0, 0,0,0,1,0,0);
    add(1,0,1,0,0,1, 0, 0,0,0,1,0,0);
    add(1,0,1,0,0,1, 0, 0,0,0,1,0,0);
    add(1,0,1,0,0,1, 0, 0,0,0,1,1,0);
    add(1,0,1,0,0,0, 0, 0,0,0,1,0,0);
    // refill to 2, then both valves
    add(1,1,0,0,0,0, 1, 0,0,0,0,0,0);
    add(1,1,0,0,0,0, 2, 0,0,0,0,0,0);
    add(1,1,1,0,0,0, 2, 0,0,0,0,0,0);
    add(1,1,1,0,0,0, 2, 0,0,0,0,0,0);
    add(1,1,1,0,0,0, 2, 0,0,0,0,0,0);
    // wash count to 5, then interlock trip and freeze
    add(1,0,0,0,1,1, 2, 0,0,0,0,0,0);
    add(1,0,0,0,1,1, 2, 0,0,0,0,0,0);
    add(1,0,0,0,1,1, 2, 0,0,0,0,0,0);
    add(1,0,0,0,1,1, 2, 0,0,0,0,0,0);
    add(1,0,0,0,1,1, 2, 0,0,0,0,0,0);
    add(0,0,0,0,1,1, 2, 0,0,0,0,0,1);
    add(1,1,0,0,1,1, 2, 0,0,0,0,0,1);
    add(1,1,0,0,1,1, 2, 0,0,0,0,0,1);
    add(1,0,1,1,0,0, 2, 0,0,0,0,0,1);

    drive(0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", obs(), 14'h0);
    @(negedge clk) rst = 1'b0;

    // reset mid-count, asynchronously between edges
    drive(1,1,0,0,0,0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_level2", obs(), {8'd2, 6'b0});
    #2;
    drive(1,0,1,0,0,0);
    rst = 1'b1;
    #1 check("async_reset_no_drain", obs(), 14'h0);
    @(negedge clk);
    drive(1,0,0,0,0,0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].lock, tbl[i].fv, tbl[i].dv,
            tbl[i].soak, tbl[i].wash, tbl[i].motor);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), obs(),
               {tbl[i].level, tbl[i].fill, tbl[i].soap, tbl[i].ct,
                tbl[i].drn, tbl[i].spin, tbl[i].fault});
    end

    // async reset clears the sticky fault
    #3;
    drive(0,0,0,0,0,0);
    rst = 1'b1;
    #1 check("fault_cleared_by_rst", obs(), 14'h0);
    @(negedge clk) rst = 1'b0;
    drive(1,1,0,0,0,0);
    @(posedge clk);
    #1 check("post_fault_refill", obs(), {8'd1, 6'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/washer_sensor_model.md
Name: washer_sensor_model

Overview:
- Plant/sensor-side counterpart of the washing-machine controller (auto_washing).
- Consumes the controller's actuator outputs (lock, fill_valve, drain_valve, soak, wash, motor).
- Generates the sensor and timer inputs the controller expects: fill, soap_add, cycle_timeout, drain, spin_timeout.
- Used for closed-loop simulation with the controller and as the timer/level front-end in the full system; also reports water level and a sticky interlock fault.

Parameters:
- FULL_LEVEL, 4: water-level count at which the tub is full.
- SOAP_CYCLES, 2: cycles from soak-while-full until soap_add.
- WASH_CYCLES, 6: cycles of wash&&motor until cycle_timeout.
- SPIN_CYCLES, 5: cycles of spin condition until spin_timeout.
- CNT_W, 8: width of level and timer counters; all counts must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lock  input  1  door lock actuator from controller.
- fill_valve  input  1  inlet valve open.
- drain_valve  input  1  drain valve open.
- soak  input  1  controller in soak phase.
- wash  input  1  controller in wash phase.
- motor  input  1  drum motor on.
- fill  output  1  tub full indication.
- soap_add  output  1  detergent dispensed.
- cycle_timeout  output  1  wash timer expired.
- drain  output  1  tub drained indication.
- spin_timeout  output  1  spin timer expired.
- level  output  CNT_W  current water level.
- fault  output  1  sticky interlock violation.

Behaviour:
- Reset (async, rst=1): level=0, all timers=0, all outputs 0, drain_seen=0. Takes effect immediately, mid-operation included.
- All state is registered on the rising edge of clk. Output flags decode combinationally from registered state; there is no extra pipeline stage.
- Level register, per edge, when fault=0:
  - fill_valve=1, drain_valve=0, level<FULL_LEVEL: level+1.
  - drain_valve=1, fill_valve=0, level>0: level-1.
  - Both valves=1: level holds.
  - Otherwise: level holds.
  - Level saturates at 0 and FULL_LEVEL; it never wraps.
- fill = (level==FULL_LEVEL).
- drain_seen: set on any edge with drain_valve=1; cleared on an edge with fill_valve=1 and drain_valve=0.
- drain = drain_seen && (level==0) && drain_valve. Never asserted out of reset until draining actually occurs.
- Soap timer:
  - Counts on each edge with soak && fill, saturating at SOAP_CYCLES.
  - Clears on any edge with soak=0.
  - soap_add = (soap_cnt==SOAP_CYCLES); held until soak drops.
- Wash timer:
  - Counts on each edge with wash && motor, saturating at WASH_CYCLES.
  - Clears on an edge with wash=0.
  - Holds (no clear) while wash=1 and motor=0.
  - cycle_timeout = (wash_cnt==WASH_CYCLES).
- Spin timer:
  - Counts on each edge with motor && !wash && drain_valve, saturating at SPIN_CYCLES.
  - Clears on an edge with motor=0.
  - spin_timeout = (spin_cnt==SPIN_CYCLES).
- Interlock:
  - If lock=0 while motor=1 or fill_valve=1 at an edge, fault sets.
  - fault is sticky until rst.
  - While fault=1: level and all timers freeze at their current values; flags stay decoded from the frozen state.
- Simultaneous events: the interlock check takes priority. On the edge fault sets, no counter updates.
- Counter comparisons are unsigned, CNT_W bits wide.

Test Plan:
- Reset mid-count: drive fill to level 2, pulse rst asynchronously (not on a clock edge) -> level=0 and all outputs 0 immediately, before the next edge.
- Fill/soak: lock=1, fill_valve=1 from t0 -> level 1,2,3,4 after edges 1–4; fill=1 after edge 4; level stays 4. Then fill_valve=0, soak=1 -> soap_add=1 after 2 edges; soak=0 -> soap_add=0 after the next edge.
- Wash timer with gap: wash=1, motor=1 for 3 edges, motor=0 for 2 edges, motor=1 for 3 edges -> cycle_timeout=1 after the 6th counting edge (8th edge overall); wash=0 -> cycle_timeout clears next edge.
- Drain/spin: from level 4, drain_valve=1 -> level 3,2,1,0 over 4 edges; drain=1 once level=0. motor=1, wash=0 -> spin_timeout=1 after 5 edges; motor=0 -> clears next edge. Confirm drain=0 immediately after reset even though level=0.
- Both valves: fill_valve=1 and drain_valve=1 at level 2 for 3 edges -> level stays 2, fault=0.
- Interlock: lock=0, motor=1 for one edge -> fault=1, level and timers frozen. Subsequent valid stimulus causes no change. rst -> fault=0.
